wasm_cmp_unit: RTL

Multi-cycle WebAssembly integer comparison unit for the CPU's numeric execute stage. It covers the full i32/i64 relational group: eqz, eq, ne, lt/gt/le/ge in signed and unsigned forms. Operands are scanned most-significant chunk first, CHUNK bits per cycle, and the scan stops early at the first differing chunk. It generalises the single fixed i32.eq path with a selectable width, parametrised datapath slicing, valid/ready handshakes and illegal-opcode reporting.

---
 rtl/wasm_cmp_pkg.sv | 38 +++
 rtl/wasm_cmp_unit_chunk.sv | 26 ++
 rtl/wasm_cmp_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/wasm_cmp_pkg.sv
// Shared opcode encodings, FSM states and opcode helpers for the wasm integer comparison unit.
package wasm_cmp_pkg;

  localparam logic [3:0] OP_EQZ  = 4'd0;
  localparam logic [3:0] OP_EQ   = 4'd1;
  localparam logic [3:0] OP_NE   = 4'd2;
  localparam logic [3:0] OP_LT_S = 4'd3;
  localparam logic [3:0] OP_LT_U = 4'd4;
  localparam logic [3:0] OP_GT_S = 4'd5;
  localparam logic [3:0] OP_GT_U = 4'd6;
  localparam logic [3:0] OP_LE_S = 4'd7;
  localparam logic [3:0] OP_LE_U = 4'd8;
  localparam logic [3:0] OP_GE_S = 4'd9;
  localparam logic [3:0] OP_GE_U = 4'd10;
  localparam logic [3:0] OP_LAST = OP_GE_U;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_e;

  function automatic logic is_signed(input logic [3:0] op);
    return (op == OP_LT_S) || (op == OP_GT_S) || (op == OP_LE_S) || (op == OP_GE_S);
  endfunction

  function automatic logic map_result(input logic [3:0] op, input logic eq, input logic lt);
    case (op)
      OP_EQZ, OP_EQ:    return eq;
      OP_NE:            return !eq;
      OP_LT_S, OP_LT_U: return lt;
      OP_GT_S, OP_GT_U: return !lt && !eq;
      OP_LE_S, OP_LE_U: return lt || eq;
      default:          return !lt;
    endcase
  endfunction

endpackage

// File: rtl/wasm_cmp_unit_chunk.sv
// One-chunk unsigned comparator; optionally flips the MSB of both sides so a
// signed top chunk compares correctly as unsigned.
module cmp_chunk #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             invert_msb,
  output logic             eq_c,
  output logic             lt_c
);

  logic [CHUNK-1:0] flip;
  logic [CHUNK-1:0] xm;
  logic [CHUNK-1:0] ym;

  always_comb begin
    flip            = '0;
    flip[CHUNK-1]   = invert_msb;
    xm              = x ^ flip;
    ym              = y ^ flip;
    eq_c            = (xm == ym);
    lt_c            = (xm < ym);
  end

endmodule

// File: rtl/wasm_cmp_unit.sv
// Multi-cycle wasm i32/i64 relational unit: scans operands MSB chunk first and
// stops at the first differing chunk.
module wasm_cmp_unit
  import wasm_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             is64,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      result,
  output logic             error
);

  localparam int unsigned NCH = 64 / CHUNK;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;

  state_e            state_q, state_d;
  logic [63:0]       a_q, a_d, b_q, b_d;
  logic [3:0]        op_q, op_d;
  logic              is64_q, is64_d;
  logic              ill_q, ill_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              res_q, res_d;
  logic              err_q, err_d;

  logic [63:0]       a_ext, b_ext;
  logic [CHUNK-1:0]  xa, xb;
  logic [CW-1:0]     top_idx;
  logic              inv_msb, eq_c, lt_c;

  always_comb begin
    a_ext            = '0;
    b_ext            = '0;
    a_ext[WIDTH-1:0] = a;
    b_ext[WIDTH-1:0] = b;
    if (!is64) begin
      a_ext[63:32] = '0;
      b_ext[63:32] = '0;
    end
    if (op == OP_EQZ) b_ext = '0;
  end

  assign top_idx = is64_q ? CW'(NCH - 1) : CW'(NCH / 2 - 1);
  assign inv_msb = is_signed(op_q) && (cnt_q == top_idx);

  always_comb begin
    xa = '0;
    xb = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cnt_q == CW'(i)) begin
        xa = a_q[i*CHUNK +: CHUNK];
        xb = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x          (xa),
    .y          (xb),
    .invert_msb (inv_msb),
    .eq_c       (eq_c),
    .lt_c       (lt_c)
  );

  // Illegal requests still pass through SCAN for one cycle so that every
  // response, legal or not, appears at least one edge after accept.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    is64_d  = is64_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a_ext;
          b_d     = b_ext;
          op_d    = op;
          is64_d  = is64;
          ill_d   = (op > OP_LAST) || (is64 && (WIDTH == 32));
          cnt_d   = is64 ? CW'(NCH - 1) : CW'(NCH / 2 - 1);
          res_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (ill_q) begin
          err_d   = 1'b1;
          res_d   = 1'b0;
          state_d = ST_DONE;
        end else if (!eq_c || (cnt_q == '0)) begin
          res_d   = map_result(op_q, eq_c, lt_c);
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      is64_q  <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      is64_q  <= is64_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = {63'b0, res_q};
  assign error     = err_q;

endmodule
